// File: rtl/string_match_multi_if.sv
// string_match_multi_if: stream, target, MD5 and match-FIFO signals of string_match_multi.
interface string_match_multi_if #(
   parameter int NUM_TARGETS = 4
);
   localparam int IW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
   logic start;
   logic [15:0] num_bytes;
   logic [5:0] str_len;
   logic [7:0] data;
   logic data_valid;
   logic tgt_wr;
   logic [IW-1:0] tgt_idx;
   logic [127:0] tgt_hash;
   logic [447:0] md5_msg;
   logic [15:0] md5_length;
   logic md5_msg_valid;
   logic [31:0] a_ret, b_ret, c_ret, d_ret;
   logic [511:0] md5_msg_ret;
   logic md5_msg_ret_valid;
   logic done, match_any;
   logic [15:0] match_count;
   logic fifo_rd, fifo_empty, fifo_overflow;
   logic [IW-1:0] fifo_idx;
   logic [15:0] fifo_pos;
   logic match_char_next;
   logic [7:0] match_char;
   modport master (
      output start, num_bytes, str_len, data, data_valid, tgt_wr, tgt_idx, tgt_hash,
             a_ret, b_ret, c_ret, d_ret, md5_msg_ret, md5_msg_ret_valid, fifo_rd, match_char_next,
      input  md5_msg, md5_length, md5_msg_valid, done, match_any, match_count,
             fifo_empty, fifo_idx, fifo_pos, fifo_overflow, match_char
   );
   modport slave (
      input  start, num_bytes, str_len, data, data_valid, tgt_wr, tgt_idx, tgt_hash,
             a_ret, b_ret, c_ret, d_ret, md5_msg_ret, md5_msg_ret_valid, fifo_rd, match_char_next,
      output md5_msg, md5_length, md5_msg_valid, done, match_any, match_count,
             fifo_empty, fifo_idx, fifo_pos, fifo_overflow, match_char
   );
endinterface

// File: rtl/string_match_multi.sv
// string_match_multi: sliding-window MD5 message builder, multi-target hash matcher and match FIFO.
// Define STRING_MATCH_CAPTURE_EN to latch the first matching message of a batch for byte readout.
module string_match_multi #(
   parameter int NUM_TARGETS = 4,
   parameter int FIFO_DEPTH = 8
) (
   input logic clk,
   input logic reset,
   string_match_multi_if.slave bus
);
   localparam int IW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FW = PW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [439:0] win, win_n;
   logic [5:0] len, len_n;
   logic [8:0] len_bits;
   logic [447:0] msg_n;
   logic [15:0] nb, cnt;
   logic [127:0] hash [NUM_TARGETS];
   logic [NUM_TARGETS-1:0] en;
   logic [127:0] ret;
   logic hit, take, push, pop, full, wr_ok;
   logic [IW-1:0] hit_idx;
   logic [IW+15:0] mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [FW-1:0] fill;
   // The newest byte sits in win[7:0]; the message left-aligns the newest len bytes and appends 0x80.
   always_comb begin
      win_n = bus.start ? '0 : win;
      if (bus.data_valid) win_n = {win_n[431:0], bus.data};
      len_n = bus.start ? bus.str_len : len;
      len_bits = {len_n, 3'b000};
      msg_n = (({8'h00, win_n} & ({448{1'b1}} >> (9'd448 - len_bits))) << (9'd448 - len_bits))
            | (448'h80 << (9'd440 - len_bits));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         win <= '0;
         len <= '0;
         bus.md5_msg <= '0;
         bus.md5_msg_valid <= 1'b0;
      end else begin
         win <= win_n;
         len <= len_n;
         bus.md5_msg_valid <= bus.data_valid;
         if (bus.data_valid) bus.md5_msg <= msg_n;
      end
   end
   assign bus.md5_length = {7'd0, len, 3'b000};
   always_ff @(posedge clk) begin
      if (reset) en <= '0;
      else if (bus.tgt_wr && int'(bus.tgt_idx) < NUM_TARGETS) begin
         en[bus.tgt_idx] <= 1'b1;
         hash[bus.tgt_idx] <= bus.tgt_hash;
      end
   end
   assign ret = {bus.a_ret, bus.b_ret, bus.c_ret, bus.d_ret};
   // Scanning downward leaves the lowest matching slot in hit_idx.
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--)
         if (en[i] && hash[i] == ret) begin
            hit = 1'b1;
            hit_idx = IW'(i);
         end
   end
   assign take = state == RUN && bus.md5_msg_ret_valid && !bus.start;
   assign push = take && hit;
   assign pop = bus.fifo_rd && fill != '0;
   assign full = fill == FW'(FIFO_DEPTH);
   assign wr_ok = push && (!full || pop);
   always_ff @(posedge clk) state <= reset ? IDLE : state_n;
   always_comb state_n = bus.start ? RUN : (state == RUN && cnt == nb) ? DONE : state;
   always_comb bus.done = state == DONE;
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         nb <= '0;
      end else if (bus.start) begin
         cnt <= '0;
         nb <= bus.num_bytes;
      end else if (take) cnt <= cnt + 16'd1;
   end
   always_ff @(posedge clk) begin
      if (reset || bus.start) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill <= '0;
         bus.fifo_overflow <= 1'b0;
         bus.match_any <= 1'b0;
         bus.match_count <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= {hit_idx, cnt};
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         fill <= fill + FW'(wr_ok) - FW'(pop);
         if (push && !wr_ok) bus.fifo_overflow <= 1'b1;
         if (push) begin
            bus.match_any <= 1'b1;
            if (~&bus.match_count) bus.match_count <= bus.match_count + 16'd1;
         end
      end
   end
   assign bus.fifo_empty = fill == '0;
   assign {bus.fifo_idx, bus.fifo_pos} = bus.fifo_empty ? '0 : mem[rd_ptr];
`ifdef STRING_MATCH_CAPTURE_EN
   logic [511:0] cap;
   always_ff @(posedge clk) begin
      if (reset || bus.start) cap <= '0;
      else if (push && !bus.match_any) cap <= bus.md5_msg_ret;
      else if (bus.match_char_next) cap <= {cap[503:0], 8'h00};
   end
   assign bus.match_char = cap[511:504];
`else
   assign bus.match_char = 8'h00;
`endif
endmodule

// File: tb/tb_string_match_multi.sv
// tb_string_match_multi: scoreboard bench for string_match_multi (messages, matches, FIFO, batch control).
module tb_string_match_multi;
   localparam int NT = 4;
   localparam int FD = 8;
   localparam logic [127:0] H1 = 128'h900150983cd24fb0d6963f7d28e17f72;
   localparam logic [127:0] H2 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] HX = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;
`ifdef STRING_MATCH_CAPTURE_EN
   localparam logic [31:0] CAP = 32'h61626380;
`else
   localparam logic [31:0] CAP = 32'h00000000;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   logic [447:0] msg_q[$];
   logic [15:0] len_q[$];
   logic [17:0] ent_q[$];
   logic [7:0] win_q[$];
   logic [127:0] slot [NT];
   bit [NT-1:0] en_m = '0;
   int len_m = 0, nb_m = 0, pos_m = 0, mc_m = 0;
   bit any_m = 0, ovf_m = 0;
   always #5 clk = ~clk;
   string_match_multi_if #(.NUM_TARGETS(NT)) bus ();
   string_match_multi #(.NUM_TARGETS(NT), .FIFO_DEPTH(FD)) dut (.clk(clk), .reset(reset), .bus(bus));
   task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [447:0] exp_msg();
      logic [447:0] m = '0;
      for (int i = 0; i < len_m; i++) begin
         int k = win_q.size() - len_m + i;
         m[447-8*i -: 8] = k >= 0 ? win_q[k] : 8'h00;
      end
      m[447-8*len_m -: 8] = 8'h80;
      return m;
   endfunction
   function automatic void push_byte(input logic [7:0] b);
      win_q.push_back(b);
      if (win_q.size() > 55) win_q.delete(0);
      msg_q.push_back(exp_msg());
      len_q.push_back(16'(len_m * 8));
   endfunction
   task automatic drive_byte(input logic [7:0] b);
      bus.data = b;
      bus.data_valid = 1'b1;
      push_byte(b);
      step();
      bus.data_valid = 1'b0;
   endtask
   task automatic write_slot(input int idx, input logic [127:0] h);
      bus.tgt_wr = 1'b1;
      bus.tgt_idx = 2'(idx);
      bus.tgt_hash = h;
      slot[idx] = h;
      en_m[idx] = 1'b1;
      step();
      bus.tgt_wr = 1'b0;
   endtask
   task automatic do_start(input int nb, input int len, input int b);
      bus.start = 1'b1;
      bus.num_bytes = 16'(nb);
      bus.str_len = 6'(len);
      win_q.delete();
      ent_q.delete();
      len_m = len; nb_m = nb; pos_m = 0; mc_m = 0; any_m = 0; ovf_m = 0;
      if (b >= 0) begin
         bus.data = 8'(b);
         bus.data_valid = 1'b1;
         push_byte(8'(b));
      end
      step();
      bus.start = 1'b0;
      bus.data_valid = 1'b0;
   endtask
   task automatic check_head();
      logic [17:0] e = ent_q.pop_front();
      check("fifo_head", 448'({bus.fifo_idx, bus.fifo_pos}), 448'(e));
   endtask
   task automatic ret(input logic [127:0] h, input bit rd);
      int idx = -1;
      {bus.a_ret, bus.b_ret, bus.c_ret, bus.d_ret} = h;
      bus.md5_msg_ret_valid = 1'b1;
      bus.fifo_rd = rd;
      if (rd && ent_q.size() > 0) check_head();
      if (pos_m < nb_m) begin
         for (int i = NT - 1; i >= 0; i--) if (en_m[i] && slot[i] == h) idx = i;
         if (idx >= 0) begin
            any_m = 1;
            if (mc_m < 65535) mc_m++;
            if (ent_q.size() < FD) ent_q.push_back({2'(idx), 16'(pos_m)});
            else ovf_m = 1;
         end
         pos_m++;
      end
      step();
      bus.md5_msg_ret_valid = 1'b0;
      bus.fifo_rd = 1'b0;
   endtask
   task automatic pop();
      if (ent_q.size() > 0) check_head();
      bus.fifo_rd = 1'b1;
      step();
      bus.fifo_rd = 1'b0;
   endtask
   task automatic check_status(input string tag);
      check({tag, "_count"}, 448'(bus.match_count), 448'(mc_m));
      check({tag, "_any"}, 448'(bus.match_any), 448'(any_m));
      check({tag, "_empty"}, 448'(bus.fifo_empty), 448'(ent_q.size() == 0));
      check({tag, "_ovf"}, 448'(bus.fifo_overflow), 448'(ovf_m));
   endtask
   always @(negedge clk)
      if (bus.md5_msg_valid) begin
         if (msg_q.size() == 0) check("msg_valid_unexpected", 448'(bus.md5_msg_valid), 448'(0));
         else begin
            check("md5_msg", bus.md5_msg, msg_q.pop_front());
            check("md5_length", 448'(bus.md5_length), 448'(len_q.pop_front()));
         end
      end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
   initial begin
      {bus.start, bus.num_bytes, bus.str_len, bus.data, bus.data_valid} = '0;
      {bus.tgt_wr, bus.tgt_idx, bus.tgt_hash, bus.fifo_rd, bus.match_char_next} = '0;
      {bus.a_ret, bus.b_ret, bus.c_ret, bus.d_ret, bus.md5_msg_ret, bus.md5_msg_ret_valid} = '0;
      step();
      step();
      check("rst_done", 448'(bus.done), 448'(0));
      check("rst_md5_valid", 448'(bus.md5_msg_valid), 448'(0));
      check("rst_md5_msg", bus.md5_msg, 448'(0));
      check("rst_md5_length", 448'(bus.md5_length), 448'(0));
      check("rst_head", 448'({bus.fifo_idx, bus.fifo_pos}), 448'(0));
      check("rst_match_char", 448'(bus.match_char), 448'(0));
      check_status("rst");
      reset = 1'b0;
      write_slot(1, H1);
      do_start(6, 3, -1);
      drive_byte(8'h61);
      drive_byte(8'h62);
      drive_byte(8'h63);
      step();
      check("md5_valid_idle", 448'(bus.md5_msg_valid), 448'(0));
      bus.md5_msg_ret = {32'h61626380, 416'h0, 64'h18};
      repeat (4) ret(HX, 0);
      ret(H1, 0);
      check("a_idx", 448'(bus.fifo_idx), 448'(1));
      check("a_pos", 448'(bus.fifo_pos), 448'(4));
      check_status("a_match");
      ret(HX, 0);
      check("a_done_early", 448'(bus.done), 448'(0));
      step();
      check("a_done", 448'(bus.done), 448'(1));
      ret(H1, 0);
      check_status("a_ignored");
      for (int i = 0; i < 4; i++) begin
         check("match_char", 448'(bus.match_char), 448'(CAP[31-8*i -: 8]));
         bus.match_char_next = 1'b1;
         step();
         bus.match_char_next = 1'b0;
      end
      pop();
      check_status("a_pop");
      write_slot(0, H2);
      write_slot(2, H2);
      do_start(20, 3, -1);
      ret(HX, 0);
      ret(H2, 0);
      check("b_idx", 448'(bus.fifo_idx), 448'(0));
      check_status("b_multi");
      pop();
      check_status("b_pop");
      do_start(40, 3, -1);
      repeat (8) ret(H1, 0);
      check_status("c_full");
      ret(H1, 1);
      check_status("c_swap");
      ret(H1, 0);
      ret(H1, 0);
      check_status("c_ovf");
      repeat (9) pop();
      check_status("c_drain");
      do_start(6, 3, -1);
      repeat (3) ret(H1, 0);
      {bus.a_ret, bus.b_ret, bus.c_ret, bus.d_ret} = H1;
      bus.md5_msg_ret_valid = 1'b1;
      do_start(6, 3, -1);
      bus.md5_msg_ret_valid = 1'b0;
      check_status("d_restart");
      repeat (5) ret(HX, 0);
      step();
      check("d_done_5", 448'(bus.done), 448'(0));
      ret(HX, 0);
      check("d_done_6", 448'(bus.done), 448'(0));
      step();
      check("d_done", 448'(bus.done), 448'(1));
      do_start(0, 1, 8'h7a);
      check("z_done_early", 448'(bus.done), 448'(0));
      step();
      check("z_done", 448'(bus.done), 448'(1));
      do_start(10, 3, -1);
      ret(H1, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      ent_q.delete();
      win_q.delete();
      en_m = '0; len_m = 0; nb_m = 0; pos_m = 0; mc_m = 0; any_m = 0; ovf_m = 0;
      check_status("e_reset");
      ret(H1, 0);
      check_status("e_idle");
      check("e_done", 448'(bus.done), 448'(0));
      do_start(4, 3, -1);
      ret(H1, 0);
      check_status("e_noslot");
      step();
      check("msg_q_left", 448'(msg_q.size()), 448'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
